// File: rtl/pcileech_bar_wifi_pkg.sv
// Shared definitions for the fake Wi-Fi BAR: register map, error codes,
// initiator FSM states and read-context tag geometry. The responder and the
// initiator both import this package so the two sides cannot disagree on the
// register addresses.
package pcileech_bar_wifi_pkg;

  localparam logic [31:0] WIFI_LINK_STATUS = 32'h0000_0000;
  localparam logic [31:0] WIFI_SCAN_RESULT = 32'h0000_0004;
  localparam logic [31:0] WIFI_SSID        = 32'h0000_0008;
  localparam logic [31:0] WIFI_RSSI        = 32'h0000_000C;
  localparam logic [31:0] WIFI_SCAN_COUNT  = 32'h0000_0010;

  localparam int CTX_W = 88;
  localparam int TAG_W = 8;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_RSP_TIMEOUT  = 2'd1,
    ERR_CTX_MISMATCH = 2'd2,
    ERR_LINK_TIMEOUT = 2'd3
  } wifi_err_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_SEL   = 4'd1,
    ST_RD_CNT   = 4'd2,
    ST_POLL     = 4'd3,
    ST_POLL_GAP = 4'd4,
    ST_RD_SSID  = 4'd5,
    ST_RD_RSSI  = 4'd6,
    ST_FIN      = 4'd7,
    ST_TRACK    = 4'd8
  } wifi_init_state_e;

endpackage

// File: rtl/pcileech_bar_rd_txn.sv
// Single-outstanding BAR read issuer. An issue pulse (accepted only when no
// read is in flight) produces a one-cycle rd_req_valid strobe carrying the
// current tag; the tag then advances mod 256. Handshake: rd_rsp_valid is
// looked at only from the cycle after the strobe until the read completes; a
// matching ctx gives rsp_ok, a different ctx gives err_ctx, and silence gives
// err_timeout in the cycle where the elapsed-cycle count reaches
// RSP_TIMEOUT-1, so the owner's registered error appears RSP_TIMEOUT cycles
// after the strobe. RSP_TIMEOUT must be at least 2.
module pcileech_bar_rd_txn
  import pcileech_bar_wifi_pkg::*;
#(
  parameter int RSP_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [31:0]      issue_addr,
  output logic [CTX_W-1:0] rd_req_ctx,
  output logic [31:0]      rd_req_addr,
  output logic             rd_req_valid,
  input  logic [CTX_W-1:0] rd_rsp_ctx,
  input  logic [31:0]      rd_rsp_data,
  input  logic             rd_rsp_valid,
  output logic             rsp_ok,
  output logic [31:0]      rsp_data,
  output logic             err_timeout,
  output logic             err_ctx
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CTX_W-1:0] ctx_q, ctx_d;
  logic [31:0]      addr_q, addr_d;
  logic             strobe_q, strobe_d;
  logic             wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: strobe -> wait, response/ctx check, timeout count, new issue.
  always_comb begin
    tag_d       = tag_q;
    ctx_d       = ctx_q;
    addr_d      = addr_q;
    strobe_d    = 1'b0;
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    rsp_ok      = 1'b0;
    err_ctx     = 1'b0;
    err_timeout = 1'b0;
    if (strobe_q) begin
      wait_d = 1'b1;
      cnt_d  = CNT_W'(1);
    end else if (wait_q) begin
      if (rd_rsp_valid) begin
        rsp_ok  = (rd_rsp_ctx == ctx_q);
        err_ctx = (rd_rsp_ctx != ctx_q);
        wait_d  = 1'b0;
        cnt_d   = '0;
      end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
        err_timeout = 1'b1;
        wait_d      = 1'b0;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (issue && !strobe_q && !wait_q) begin
      strobe_d = 1'b1;
      addr_d   = issue_addr;
      ctx_d    = {{(CTX_W - TAG_W){1'b0}}, tag_q};
      tag_d    = tag_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= '0;
      ctx_q    <= '0;
      addr_q   <= '0;
      strobe_q <= 1'b0;
      wait_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      tag_q    <= tag_d;
      ctx_q    <= ctx_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_req_ctx   = ctx_q;
  assign rd_req_addr  = addr_q;
  assign rd_req_valid = strobe_q;
  assign rsp_data     = rd_rsp_data;

endmodule

// File: rtl/pcileech_bar_initiator_wifi.sv
// Host-driver style initiator for the fake Wi-Fi BAR: selects a network,
// reads the scan count, polls link status until connected, then reads SSID
// and RSSI. Optional macro WIFI_INIT_RSSI_TRACK_EN keeps re-reading RSSI every
// TRACK_PERIOD cycles after a successful run. Errors are sticky until the
// next accepted start; result registers keep their last values.
module pcileech_bar_initiator_wifi
  import pcileech_bar_wifi_pkg::*;
#(
  parameter int POLL_GAP     = 64,
  parameter int MAX_POLLS    = 256,
  parameter int RSP_TIMEOUT  = 32,
  parameter int TRACK_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       select_index,
  output logic [31:0]      wr_addr,
  output logic [3:0]       wr_be,
  output logic [31:0]      wr_data,
  output logic             wr_valid,
  output logic [CTX_W-1:0] rd_req_ctx,
  output logic [31:0]      rd_req_addr,
  output logic             rd_req_valid,
  input  logic [CTX_W-1:0] rd_rsp_ctx,
  input  logic [31:0]      rd_rsp_data,
  input  logic             rd_rsp_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       error_code,
  output logic             link_up,
  output logic [7:0]       scan_count,
  output logic [31:0]      ssid,
  output logic [7:0]       rssi
);

  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int TRK_W  = $clog2(TRACK_PERIOD + 1);

  wifi_init_state_e state_q, state_d;
  wifi_err_e        error_code_q, error_code_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, ssid_q, ssid_d;
  logic [3:0]  wr_be_q, wr_be_d;
  logic        wr_valid_q, wr_valid_d, busy_q, busy_d, done_q, done_d;
  logic        error_q, error_d, link_up_q, link_up_d, pend_q, pend_d;
  logic        start_pend_q, start_pend_d;
  logic [7:0]  scan_count_q, scan_count_d, rssi_q, rssi_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TRK_W-1:0]  track_cnt_q, track_cnt_d;

  logic        issue, begin_seq;
  logic [31:0] issue_addr, txn_rsp_data;
  logic        txn_rsp_ok, txn_err_timeout, txn_err_ctx;

  pcileech_bar_rd_txn #(.RSP_TIMEOUT(RSP_TIMEOUT)) u_rd_txn (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .issue_addr   (issue_addr),
    .rd_req_ctx   (rd_req_ctx),
    .rd_req_addr  (rd_req_addr),
    .rd_req_valid (rd_req_valid),
    .rd_rsp_ctx   (rd_rsp_ctx),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_valid (rd_rsp_valid),
    .rsp_ok       (txn_rsp_ok),
    .rsp_data     (txn_rsp_data),
    .err_timeout  (txn_err_timeout),
    .err_ctx      (txn_err_ctx)
  );

  // Sequence FSM next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;      error_code_d = error_code_q;
    sel_d        = sel_q;        wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;    wr_be_d      = wr_be_q;
    wr_valid_d   = 1'b0;         busy_d       = busy_q;
    done_d       = 1'b0;         error_d      = error_q;
    link_up_d    = link_up_q;    scan_count_d = scan_count_q;
    ssid_d       = ssid_q;       rssi_d       = rssi_q;
    pend_d       = pend_q;       poll_cnt_d   = poll_cnt_q;
    gap_cnt_d    = gap_cnt_q;    track_cnt_d  = track_cnt_q;
    start_pend_d = start_pend_q;
    issue        = 1'b0;
    issue_addr   = WIFI_LINK_STATUS;
    begin_seq    = 1'b0;
    case (state_q)
      ST_IDLE: begin_seq = start;
      ST_WR_SEL: begin
        wr_valid_d = 1'b1;
        wr_addr_d  = WIFI_SCAN_RESULT;
        wr_be_d    = 4'hF;
        wr_data_d  = {30'b0, sel_q};
        state_d    = ST_RD_CNT;
      end
      ST_RD_CNT: begin
        issue_addr = WIFI_SCAN_COUNT;
        if (txn_rsp_ok) begin
          scan_count_d = txn_rsp_data[7:0];
          pend_d       = 1'b0;
          state_d      = ST_POLL;
        end
      end
      ST_POLL: begin
        issue_addr = WIFI_LINK_STATUS;
        if (txn_rsp_ok) begin
          pend_d     = 1'b0;
          link_up_d  = txn_rsp_data[0];
          poll_cnt_d = poll_cnt_q + 1'b1;
          gap_cnt_d  = '0;
          if (txn_rsp_data[0]) begin
            state_d = ST_RD_SSID;
          end else if (poll_cnt_q == POLL_W'(MAX_POLLS - 1)) begin
            error_d      = 1'b1;
            error_code_d = ERR_LINK_TIMEOUT;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_POLL_GAP;
          end
        end
      end
      ST_POLL_GAP: begin
        if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) state_d = ST_POLL;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      ST_RD_SSID: begin
        issue_addr = WIFI_SSID;
        if (txn_rsp_ok) begin
          ssid_d  = txn_rsp_data;
          pend_d  = 1'b0;
          state_d = ST_RD_RSSI;
        end
      end
      ST_RD_RSSI: begin
        issue_addr = WIFI_RSSI;
        if (txn_rsp_ok) begin
          rssi_d  = txn_rsp_data[7:0];
          pend_d  = 1'b0;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
`ifdef WIFI_INIT_RSSI_TRACK_EN
        state_d      = ST_TRACK;
        track_cnt_d  = '0;
        start_pend_d = 1'b0;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_TRACK: begin
`ifdef WIFI_INIT_RSSI_TRACK_EN
        // Free-running period counter so strobes land exactly TRACK_PERIOD apart.
        track_cnt_d = (track_cnt_q == TRK_W'(TRACK_PERIOD - 1)) ? '0 : track_cnt_q + 1'b1;
        if (pend_q && txn_rsp_ok) begin
          rssi_d = txn_rsp_data[7:0];
          pend_d = 1'b0;
        end
        if (start || start_pend_q) begin
          // A start arriving mid-read is held until that read completes.
          if (!pend_q) begin_seq = 1'b1;
          else start_pend_d = 1'b1;
        end else if (!pend_q && track_cnt_q == TRK_W'(TRACK_PERIOD - 1)) begin
          issue      = 1'b1;
          issue_addr = WIFI_RSSI;
          pend_d     = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Every sequence read state issues once on entry, then waits.
    if (!pend_q && (state_q == ST_RD_CNT || state_q == ST_POLL ||
                    state_q == ST_RD_SSID || state_q == ST_RD_RSSI)) begin
      issue  = 1'b1;
      pend_d = 1'b1;
    end
    if (begin_seq) begin
      busy_d       = 1'b1;
      error_d      = 1'b0;
      error_code_d = ERR_NONE;
      sel_d        = select_index;
      poll_cnt_d   = '0;
      start_pend_d = 1'b0;
      state_d      = ST_WR_SEL;
    end
    // Transaction errors override whatever the state wanted this cycle.
    if (state_q != ST_IDLE && (txn_err_timeout || txn_err_ctx)) begin
      error_d      = 1'b1;
      error_code_d = txn_err_timeout ? ERR_RSP_TIMEOUT : ERR_CTX_MISMATCH;
      busy_d       = 1'b0;
      pend_d       = 1'b0;
      start_pend_d = 1'b0;
      state_d      = ST_IDLE;
    end
  end

  // All FSM state and outputs registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;      error_code_q <= ERR_NONE;
      sel_q <= '0;             wr_addr_q <= '0;     wr_data_q <= '0;
      wr_be_q <= '0;           wr_valid_q <= 1'b0;  busy_q <= 1'b0;
      done_q <= 1'b0;          error_q <= 1'b0;     link_up_q <= 1'b0;
      scan_count_q <= '0;      ssid_q <= '0;        rssi_q <= '0;
      pend_q <= 1'b0;          poll_cnt_q <= '0;    gap_cnt_q <= '0;
      track_cnt_q <= '0;       start_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;      error_code_q <= error_code_d;
      sel_q <= sel_d;          wr_addr_q <= wr_addr_d;   wr_data_q <= wr_data_d;
      wr_be_q <= wr_be_d;      wr_valid_q <= wr_valid_d; busy_q <= busy_d;
      done_q <= done_d;        error_q <= error_d;       link_up_q <= link_up_d;
      scan_count_q <= scan_count_d; ssid_q <= ssid_d;    rssi_q <= rssi_d;
      pend_q <= pend_d;        poll_cnt_q <= poll_cnt_d; gap_cnt_q <= gap_cnt_d;
      track_cnt_q <= track_cnt_d; start_pend_q <= start_pend_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_be      = wr_be_q;
  assign wr_data    = wr_data_q;
  assign wr_valid   = wr_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_code = error_code_q;
  assign link_up    = link_up_q;
  assign scan_count = scan_count_q;
  assign ssid       = ssid_q;
  assign rssi       = rssi_q;

endmodule

// File: tb/tb_pcileech_bar_initiator_wifi.sv
// Directed bench for pcileech_bar_initiator_wifi with a behavioural fake
// Wi-Fi BAR responder (1-cycle read latency, fault knobs for dropped
// responses, corrupted ctx and link never coming up).
module tb_pcileech_bar_initiator_wifi;
  import pcileech_bar_wifi_pkg::*;

  localparam int RSP_TIMEOUT = 32;

  logic             clk, rst, start;
  logic [1:0]       select_index;
  logic [31:0]      wr_addr, wr_data, rd_req_addr, rd_rsp_data, ssid;
  logic [3:0]       wr_be;
  logic             wr_valid, rd_req_valid, rd_rsp_valid;
  logic [CTX_W-1:0] rd_req_ctx, rd_rsp_ctx;
  logic             busy, done, error, link_up;
  logic [1:0]       error_code;
  logic [7:0]       scan_count, rssi;

  pcileech_bar_initiator_wifi #(
    .POLL_GAP(500), .MAX_POLLS(8), .RSP_TIMEOUT(RSP_TIMEOUT), .TRACK_PERIOD(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .select_index(select_index),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
    .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .link_up(link_up), .scan_count(scan_count), .ssid(ssid), .rssi(rssi)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];   // expected wr_data of each upcoming write

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- responder model ----------------
  logic        link_en = 1'b0;
  int          link_at = 0;
  logic [31:0] drop_addr = 32'hFFFF_FFFF;
  logic [31:0] bad_ctx_addr = 32'hFFFF_FFFF;
  logic [7:0]  rssi_reg = 8'd60;
  logic        rssi_track_mode = 1'b0;
  logic        inj_req = 1'b0;
  logic [CTX_W-1:0] inj_ctx, last_ctx, pend_ctx;
  logic [31:0] pend_data;
  logic        rsp_pend = 1'b0;
  logic [7:0]  exp_tag = 8'd0;
  int n_wr = 0, n_poll = 0, n_rssi_rd = 0, n_rd_total = 0;
  int ssid_req_cyc = 0, rssi_req_cyc = 0, rssi_req_prev = 0;

  initial begin
    rd_rsp_valid = 1'b0;
    rd_rsp_ctx   = '0;
    rd_rsp_data  = '0;
  end

  always @(posedge clk) begin
    #1;
    if (!rst) exp_tag = 8'd0;
    rd_rsp_valid = 1'b0;
    if (inj_req) begin
      rd_rsp_valid = 1'b1; rd_rsp_ctx = inj_ctx; rd_rsp_data = 32'h1; inj_req = 1'b0;
    end else if (rsp_pend) begin
      rd_rsp_valid = 1'b1; rd_rsp_ctx = pend_ctx; rd_rsp_data = pend_data; rsp_pend = 1'b0;
    end
    if (wr_valid) begin
      n_wr++;
      check("wr_addr", wr_addr, 32'h4);
      check("wr_be", {28'b0, wr_be}, 32'hF);
      check("wr_expected", exp_q.size(), 1);
      if (exp_q.size() > 0) check("wr_data", wr_data, exp_q.pop_front());
    end
    if (rd_req_valid) begin
      n_rd_total++;
      check("req_tag", {24'b0, rd_req_ctx[7:0]}, {24'b0, exp_tag});
      check("req_ctx_hi", {31'b0, |rd_req_ctx[CTX_W-1:8]}, 0);
      exp_tag  = exp_tag + 8'd1;
      last_ctx = rd_req_ctx;
      case (rd_req_addr)
        WIFI_LINK_STATUS: begin n_poll++; pend_data = {31'b0, link_en && (cyc >= link_at)}; end
        WIFI_SCAN_COUNT:  pend_data = 32'd4;
        WIFI_SSID:        begin ssid_req_cyc = cyc; pend_data = 32'h426F7373; end
        WIFI_RSSI: begin
          n_rssi_rd++; rssi_req_prev = rssi_req_cyc; rssi_req_cyc = cyc;
          pend_data = {24'b0, rssi_reg};
          if (rssi_track_mode && rssi_reg > 8'd45) rssi_reg = rssi_reg - 8'd1;
        end
        default: pend_data = 32'h0;
      endcase
      pend_ctx = rd_req_ctx;
      if (rd_req_addr == bad_ctx_addr) pend_ctx[7:0] = rd_req_ctx[7:0] + 8'd1;
      rsp_pend = (rd_req_addr != drop_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [1:0] idx);
    @(negedge clk); start = 1'b1; select_index = idx;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output logic got_done, output int end_cyc);
    logic seen;
    seen = 1'b0; got_done = 1'b0; end_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        got_done = done; end_cyc = cyc; seen = 1'b1;
        break;
      end
    end
    check("seq_end_seen", {31'b0, seen}, 1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, {31'b0, busy}, 0);
    check({pfx, "_done"}, {31'b0, done}, 0);
    check({pfx, "_error"}, {31'b0, error}, 0);
    check({pfx, "_code"}, {30'b0, error_code}, 0);
    check({pfx, "_wr_valid"}, {31'b0, wr_valid}, 0);
    check({pfx, "_wr_addr"}, wr_addr, 0);
    check({pfx, "_wr_data"}, wr_data, 0);
    check({pfx, "_rd_valid"}, {31'b0, rd_req_valid}, 0);
    check({pfx, "_rd_addr"}, rd_req_addr, 0);
    check({pfx, "_rd_ctx"}, rd_req_ctx[31:0], 0);
    check({pfx, "_link_up"}, {31'b0, link_up}, 0);
    check({pfx, "_scan"}, {24'b0, scan_count}, 0);
    check({pfx, "_ssid"}, ssid, 0);
    check({pfx, "_rssi"}, {24'b0, rssi}, 0);
    check({pfx, "_state"}, {28'b0, dut.state_q}, {28'b0, ST_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic got_done;
    int   end_cyc;
    rst = 1'b0; start = 1'b0; select_index = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: normal run, link comes up 3000 cycles after start
    link_en = 1'b1; link_at = cyc + 3000; n_wr = 0;
    exp_q.push_back(32'd2);
    do_start(2'd2);
    check("t1_busy", {31'b0, busy}, 1);
    wait_end(6000, got_done, end_cyc);
    check("t1_done", {31'b0, got_done}, 1);
    check("t1_error", {31'b0, error}, 0);
    check("t1_busy_end", {31'b0, busy}, 0);
    check("t1_scan", {24'b0, scan_count}, 4);
    check("t1_ssid", ssid, 32'h426F7373);
    check("t1_rssi", {24'b0, rssi}, 60);
    check("t1_link", {31'b0, link_up}, 1);
    check("t1_n_wr", n_wr, 1);
    @(negedge clk);
    check("t1_done_pulse", {31'b0, done}, 0);

    // 2: link never rises -> 8 polls then link timeout
    link_en = 1'b0; n_poll = 0;
    exp_q.push_back(32'd1);
    do_start(2'd1);
    wait_end(6000, got_done, end_cyc);
    check("t2_no_done", {31'b0, got_done}, 0);
    check("t2_error", {31'b0, error}, 1);
    check("t2_code", {30'b0, error_code}, 3);
    check("t2_busy", {31'b0, busy}, 0);
    check("t2_polls", n_poll, 8);
    check("t2_link", {31'b0, link_up}, 0);

    // 3: SSID response dropped -> timeout exactly RSP_TIMEOUT cycles later
    link_en = 1'b1; link_at = 0; drop_addr = WIFI_SSID;
    exp_q.push_back(32'd0);
    do_start(2'd0);
    check("t3_error_cleared", {31'b0, error}, 0);
    wait_end(3000, got_done, end_cyc);
    check("t3_code", {30'b0, error_code}, 1);
    check("t3_latency", end_cyc - ssid_req_cyc, RSP_TIMEOUT);
    check("t3_busy", {31'b0, busy}, 0);
    check("t3_ssid_kept", ssid, 32'h426F7373);
    drop_addr = 32'hFFFF_FFFF;

    // 4: RSSI response with tag+1 -> ctx mismatch, rssi unchanged
    bad_ctx_addr = WIFI_RSSI; rssi_reg = 8'd50;
    exp_q.push_back(32'd3);
    do_start(2'd3);
    wait_end(3000, got_done, end_cyc);
    check("t4_no_done", {31'b0, got_done}, 0);
    check("t4_code", {30'b0, error_code}, 2);
    check("t4_busy", {31'b0, busy}, 0);
    check("t4_rssi_kept", {24'b0, rssi}, 60);
    bad_ctx_addr = 32'hFFFF_FFFF; rssi_reg = 8'd60;

    // 5: reset in the middle of polling, stale responses afterwards
    link_en = 1'b0; n_poll = 0;
    exp_q.push_back(32'd2);
    do_start(2'd2);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_req_valid && rd_req_addr == WIFI_LINK_STATUS && n_poll >= 2) break;
    end
    check("t5_second_poll", n_poll, 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("t5_rst");
    rst = 1'b1;
    @(negedge clk);
    inj_ctx = last_ctx; inj_req = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("t5_stale");
    link_en = 1'b1; link_at = 0; rssi_track_mode = 1'b1;
    exp_q.push_back(32'd1);
    do_start(2'd1);
    wait_end(3000, got_done, end_cyc);
    check("t5_done", {31'b0, got_done}, 1);
    check("t5_error", {31'b0, error}, 0);
    check("t5_scan", {24'b0, scan_count}, 4);
    check("t5_ssid", ssid, 32'h426F7373);
    check("t5_rssi", {24'b0, rssi}, 60);
    check("t5_exp_q_empty", exp_q.size(), 0);

    // 6: behaviour after done
    n_rssi_rd = 0; n_rd_total = 0;
    repeat (350) @(negedge clk);
`ifdef WIFI_INIT_RSSI_TRACK_EN
    check("t6_track_reads", n_rssi_rd, 3);
    check("t6_track_period", rssi_req_cyc - rssi_req_prev, 100);
    check("t6_track_rssi", {24'b0, rssi}, 57);
`else
    check("t6_no_reads", n_rd_total, 0);
    check("t6_rssi_held", {24'b0, rssi}, 60);
`endif
    check("t6_busy", {31'b0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
